pmsm_phase_current_gen: RTL and testbench

//  Downstream of the PMSM state solver in the HIL motor model. On each solver valid pulse it

---
 rtl/pmsm_phase_current_gen.sv | 195 +++++++++++++++++++
 tb/tb_pmsm_phase_current_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmsm_phase_current_gen.sv
// pmsm_phase_current_gen
//   Converts the solver's rotor-frame currents (id, iq) and electrical angle
//   (theta) into saturated stator phase currents ia/ib/ic. The conversion is
//   an inverse Park followed by an inverse Clarke. A single shared multiplier
//   does the work, so there is one result every 8 clocks.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            low forces the FSM to IDLE; outputs hold; in_valid ignored
//   in_valid          one-cycle pulse, id/iq/theta valid in that cycle
//   id, iq            signed W-bit d/q currents
//   theta             W-bit angle, 2^W == one electrical turn
//   clear_ovr         clears the sticky overrun flag
//   busy              high whenever the FSM is not in IDLE
//   out_valid         one-cycle pulse; ia/ib/ic/sat updated in that cycle
//   ia, ib, ic        signed OUT_W-bit saturated phase currents
//   sat               at least one phase clipped in the latest result
//   overrun           sticky; a sample arrived while busy and was dropped
//   dbg_state         current FSM state, for observation only
//
// Handshake: there is no ready signal. An in_valid pulse is accepted only
// while busy is low and enable is high. A pulse that arrives while busy is
// dropped and sets overrun, and the computation in flight carries on.
// out_valid is a one-cycle pulse and the outputs hold until the next pulse.
module pmsm_phase_current_gen #(
  parameter int W         = 35,
  parameter int LUT_AW    = 10,
  parameter int SIN_W     = 18,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic signed [W-1:0]     id,
  input  logic signed [W-1:0]     iq,
  input  logic        [W-1:0]     theta,
  input  logic                    clear_ovr,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] ia,
  output logic signed [OUT_W-1:0] ib,
  output logic signed [OUT_W-1:0] ic,
  output logic                    sat,
  output logic                    overrun,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LUT, S_M0, S_M1, S_M2, S_M3, S_MK, S_CLK
  } state_t;

  localparam int  ROM_N = 2 ** LUT_AW;
  localparam real PI    = 3.14159265358979323846;
  localparam real ONE   = 2.0 ** (SIN_W - 2);
  // sqrt(3)/2 in the same fixed-point scale as the sine table.
  localparam logic signed [SIN_W-1:0] K_W = SIN_W'(int'(0.8660254 * ONE));
  localparam logic signed [W+2:0] SAT_MAX = (W+3)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W+2:0] SAT_MIN = -(W+3)'(2 ** (OUT_W - 1));

  state_t state, state_n;

  // Full-wave sine table. The entries are constants fixed at elaboration.
  logic signed [SIN_W-1:0] rom [ROM_N];
  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam int V = int'($sin(2.0 * PI * k / ROM_N) * ONE);
    assign rom[k] = SIN_W'(V);
  end

  logic signed [W-1:0]      id_r, iq_r;
  logic [LUT_AW-1:0]        addr_r, addr_c;
  logic signed [SIN_W-1:0]  sin_r, cos_r;
  logic signed [W+1:0]      alpha, beta, bk;

  logic signed [W+1:0]       mul_a;
  logic signed [SIN_W-1:0]   mul_b;
  logic signed [W+SIN_W+1:0] prod;
  logic signed [W+1:0]       prod_sh;

  logic signed [W+2:0] xa, xb, xc, ha, sa, sb, sc;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  // The cosine is read from the same table, a quarter turn ahead of the sine.
  assign addr_c    = addr_r + LUT_AW'(ROM_N / 4);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (in_valid) state_n = S_LUT;
      S_LUT:   state_n = S_M0;
      S_M0:    state_n = S_M1;
      S_M1:    state_n = S_M2;
      S_M2:    state_n = S_M3;
      S_M3:    state_n = S_MK;
      S_MK:    state_n = S_CLK;
      S_CLK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (!enable) state_n = S_IDLE;
  end

  // Shared multiplier operand select. Every product is scaled back by the
  // table's unity weight using a floor shift.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_M0:    begin mul_a = (W+2)'(id_r); mul_b = cos_r; end
      S_M1:    begin mul_a = (W+2)'(iq_r); mul_b = sin_r; end
      S_M2:    begin mul_a = (W+2)'(id_r); mul_b = sin_r; end
      S_M3:    begin mul_a = (W+2)'(iq_r); mul_b = cos_r; end
      S_MK:    begin mul_a = beta;         mul_b = K_W;   end
      default: begin mul_a = '0;           mul_b = '0;    end
    endcase
    prod    = (W+SIN_W+2)'(mul_a) * (W+SIN_W+2)'(mul_b);
    prod_sh = (W+2)'(prod >>> (SIN_W - 2));
  end

  // Inverse Clarke on one guard bit beyond the accumulators.
  always_comb begin
    xa = (W+3)'(alpha);
    ha = xa >>> 1;
    xb = (W+3)'(bk) - ha;
    xc = -(W+3)'(bk) - ha;
    sa = xa >>> OUT_SHIFT;
    sb = xb >>> OUT_SHIFT;
    sc = xc >>> OUT_SHIFT;
  end

  function automatic logic signed [OUT_W-1:0] clip(input logic signed [W+2:0] v);
    if (v > SAT_MAX)      return OUT_W'(SAT_MAX);
    else if (v < SAT_MIN) return OUT_W'(SAT_MIN);
    else                  return OUT_W'(v);
  endfunction

  function automatic logic clipped(input logic signed [W+2:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      id_r      <= '0;
      iq_r      <= '0;
      addr_r    <= '0;
      sin_r     <= '0;
      cos_r     <= '0;
      alpha     <= '0;
      beta      <= '0;
      bk        <= '0;
      ia        <= '0;
      ib        <= '0;
      ic        <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (enable && in_valid) begin
          id_r   <= id;
          iq_r   <= iq;
          addr_r <= LUT_AW'(theta >> (W - LUT_AW));
        end
        S_LUT: begin
          sin_r <= rom[addr_r];
          cos_r <= rom[addr_c];
        end
        S_M0: alpha <= prod_sh;
        S_M1: alpha <= alpha - prod_sh;
        S_M2: beta  <= prod_sh;
        S_M3: beta  <= beta + prod_sh;
        S_MK: bk    <= prod_sh;
        S_CLK: if (enable) begin
          ia        <= clip(sa);
          ib        <= clip(sb);
          ic        <= clip(sc);
          sat       <= clipped(sa) | clipped(sb) | clipped(sc);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
      // If a new overrun and clear_ovr happen in the same cycle, the set wins.
      if (enable && in_valid && (state != S_IDLE)) overrun <= 1'b1;
      else if (clear_ovr)                          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmsm_phase_current_gen.sv
module tb_pmsm_phase_current_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic [34:0] id = '0;
  logic [34:0] iq = '0;
  logic [34:0] theta = '0;
  logic        clear_ovr = 1'b0;
  logic        busy, out_valid, sat, overrun;
  logic signed [15:0] ia, ib, ic;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  pmsm_phase_current_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .id(id), .iq(iq), .theta(theta), .clear_ovr(clear_ovr),
    .busy(busy), .out_valid(out_valid), .ia(ia), .ib(ib), .ic(ic),
    .sat(sat), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int rom_m [1024];

  task automatic build_rom();
    for (int k = 0; k < 1024; k++)
      rom_m[k] = int'($sin(2.0 * 3.14159265358979323846 * k / 1024.0) * 65536.0);
  endtask

  // Inverse Park + inverse Clarke in plain integer arithmetic, unclipped.
  function automatic void phase_model(input longint di, input longint dq,
                                      input logic [34:0] th,
                                      output longint ra, output longint rb,
                                      output longint rc);
    int as_i, ac_i;
    longint sn, cs, al, be, bkv, hav;
    as_i = int'(th[34:25]);
    ac_i = (as_i + 256) % 1024;
    sn  = rom_m[as_i];
    cs  = rom_m[ac_i];
    al  = ((di * cs) >>> 16) - ((dq * sn) >>> 16);
    be  = ((di * sn) >>> 16) + ((dq * cs) >>> 16);
    bkv = (be * 56756) >>> 16;
    hav = al >>> 1;
    ra = al;
    rb = bkv - hav;
    rc = -bkv - hav;
  endfunction

  function automatic longint clip16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit is_clip(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Transaction-level expectation: an accepted sample comes out 8 cycles
  // later unless reset or enable-low intervenes; samples during that window
  // are dropped and flagged.
  bit     m_pend = 1'b0;
  int     m_left = 0;
  longint p_ia, p_ib, p_ic;
  bit     p_sat;
  bit     e_valid = 1'b0, e_busy = 1'b0, e_ovr = 1'b0, e_sat = 1'b0;
  longint e_ia = 0, e_ib = 0, e_ic = 0;

  always @(posedge clk) begin
    longint ra, rb, rc;
    bit ov_set;
    ov_set  = 1'b0;
    e_valid = 1'b0;
    if (rst) begin
      m_pend = 1'b0;
      e_ia = 0; e_ib = 0; e_ic = 0; e_sat = 1'b0; e_ovr = 1'b0;
    end else begin
      if (!enable) begin
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (in_valid) ov_set = 1'b1;
        m_left--;
        if (m_left == 0) begin
          e_valid = 1'b1;
          e_ia = p_ia; e_ib = p_ib; e_ic = p_ic; e_sat = p_sat;
          m_pend = 1'b0;
        end
      end else if (in_valid) begin
        phase_model(longint'($signed(id)), longint'($signed(iq)), theta, ra, rb, rc);
        p_ia  = clip16(ra);
        p_ib  = clip16(rb);
        p_ic  = clip16(rc);
        p_sat = is_clip(ra) | is_clip(rb) | is_clip(rc);
        m_pend = 1'b1;
        m_left = 7;
      end
      if (ov_set)         e_ovr = 1'b1;
      else if (clear_ovr) e_ovr = 1'b0;
    end
    e_busy = m_pend;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, e_valid);
      check("busy", busy, e_busy);
      check("overrun", overrun, e_ovr);
      check("ia", ia, e_ia);
      check("ib", ib, e_ib);
      check("ic", ic, e_ic);
      check("sat", sat, e_sat);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input longint di, input longint dq,
                       input logic [34:0] th, input bit en, input bit r,
                       input bit clr);
    @(negedge clk);
    in_valid  = v;
    id        = di[34:0];
    iq        = dq[34:0];
    theta     = th;
    enable    = en;
    rst       = r;
    clear_ovr = clr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse(input longint di, input longint dq, input logic [34:0] th);
    drive(1'b1, di, dq, th, 1'b1, 1'b0, 1'b0);
  endtask

  // Cycles after the pulse until out_valid is seen; -1 if it never comes.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      idle();
      if (out_valid === 1'b1) cnt++;
    end
  endtask

  task automatic directed(input string name, input longint di, input longint dq,
                          input logic [34:0] th, input longint xa,
                          input longint xb, input longint xc, input bit xs);
    int lat;
    pulse(di, dq, th);
    wait_out(lat);
    check({name, "_latency"}, lat, 8);
    check({name, "_ia"}, ia, xa);
    check({name, "_ib"}, ib, xb);
    check({name, "_ic"}, ic, xc);
    check({name, "_sat"}, sat, xs);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint ra, rb, rc, di, dq;
    logic [34:0] th;
    int cnt, lat;

    build_rom();

    // Pin the model to hand-worked values.
    phase_model(1000, 0, 35'd0, ra, rb, rc);
    check("model_t1_ia", ra, 1000);
    check("model_t1_ib", rb, -500);
    check("model_t1_ic", rc, -500);
    phase_model(0, 65536, 35'd0, ra, rb, rc);
    check("model_raw_ib", rb, 56756);
    check("model_raw_ic", rc, -56756);
    phase_model(0, 1000, 35'h2_0000_0000, ra, rb, rc);
    check("model_t2_ia", ra, -1000);

    // Reset.
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_ia", ia, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    drive(1'b0, 0, 0, '0, 1'b1, 1'b1, 1'b0);
    idle();

    // Spec vectors.
    directed("t1", 1000, 0, 35'd0, 1000, -500, -500, 1'b0);
    directed("t2", 0, 1000, 35'h2_0000_0000, -1000, 500, 500, 1'b0);
    directed("t3", 0, 65536, 35'd0, 0, 32767, -32768, 1'b1);
    directed("t4", 100000, 0, 35'd0, 32767, -32768, -32768, 1'b1);

    // Overrun: pulses at relative cycles 0 and 3, so only the first completes.
    pulse(2000, 0, 35'd0);
    idle();
    idle();
    pulse(7000, 0, 35'd0);
    wait_out(lat);
    check("ovr_latency", lat, 5);
    check("ovr_ia_first_sample", ia, 2000);
    check("ovr_flag", overrun, 1);
    count_pulses(10, cnt);
    check("ovr_dropped_no_pulse", cnt, 0);
    drive(1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b1);
    idle();
    check("ovr_cleared", overrun, 0);

    // Reset in the middle of an operation.
    pulse(3000, 0, 35'd0);
    idle();
    idle();
    idle();
    drive(1'b0, 0, 0, '0, 1'b1, 1'b1, 1'b0);
    count_pulses(8, cnt);
    check("rst_abort_no_pulse", cnt, 0);
    check("rst_abort_ia", ia, 0);
    check("rst_abort_ib", ib, 0);

    // Back-to-back: the next sample arrives in the out_valid cycle.
    pulse(1500, 0, 35'd0);
    for (int k = 0; k < 7; k++) idle();
    pulse(-1200, 0, 35'd0);
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_ia", ia, 1500);
    for (int k = 0; k < 7; k++) idle();
    idle();
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_ia", ia, -1200);

    // Enable dropped mid-operation.
    pulse(4000, 0, 35'd0);
    idle();
    idle();
    drive(1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
    count_pulses(10, cnt);
    check("en_abort_no_pulse", cnt, 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0:       di = longint'($signed(35'({$urandom(), $urandom()})));
        default: di = longint'($urandom_range(0, 80000)) - 40000;
      endcase
      case ($urandom_range(0, 3))
        0:       dq = longint'($signed(35'({$urandom(), $urandom()})));
        1:       dq = -(64'sd1 <<< 34);
        default: dq = longint'($urandom_range(0, 80000)) - 40000;
      endcase
      th = 35'({$urandom(), $urandom()});
      drive(($urandom_range(0, 5) == 0), di, dq, th,
            ($urandom_range(0, 40) != 0), ($urandom_range(0, 200) == 0),
            ($urandom_range(0, 15) == 0));
    end
    for (int k = 0; k < 10; k++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
